vesa_timing_gen_prog: RTL and testbench
=======================================

Name: vesa_timing_gen_prog

Overview:
- Runtime-programmable VESA timing generator; successor to the fixed per-mode timing generators.
- Counter width, default mode and sync polarity are parameters. Timing and polarity can be reloaded at run time through a valid/ready config port.
- New config is shadowed and applied only at a frame boundary. Adds enable control, frame/line start strobes and active-pixel coordinates.
- Sits between the pixel clock domain and the video pipeline / TMDS encoder.

Parameters:
- CNT_W, 12, width of all counters and timing fields.
- DEF_H_ACTIVE, 1280, reset horizontal active pixels.
- DEF_H_FP, 144, reset horizontal front porch.
- DEF_H_SYNC, 32, reset horizontal sync width.
- DEF_H_BP, 144, reset horizontal back porch.
- DEF_V_ACTIVE, 720, reset vertical active lines.
- DEF_V_FP, 3, reset vertical front porch.
- DEF_V_SYNC, 4, reset vertical sync width.
- DEF_V_BP, 21, reset vertical back porch.
- DEF_HS_POL, 0, reset hsync active level (1 = active-high).
- DEF_VS_POL, 0, reset vsync active level.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  reset, synchronous, active-low
- en  in  1  run enable
- cfg_valid  in  1  config offer
- cfg_ready  out  1  config accept possible
- cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp  in  CNT_W each  horizontal fields
- cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp  in  CNT_W each  vertical fields
- cfg_hs_pol, cfg_vs_pol  in  1 each  sync polarities
- cfg_err  out  1  one-cycle pulse, offered config rejected
- hsync, vsync  out  1  sync outputs, polarity per active config
- de  out  1  active pixel
- frame_valid  out  1  active line region
- frame_start  out  1  one-cycle pulse, first active pixel of frame
- line_start  out  1  one-cycle pulse, first active pixel of each active line
- h_count, v_count  out  CNT_W  raw counters
- x_pos, y_pos  out  CNT_W  active coordinates, valid when de

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is synchronous and active-low, sampled on posedge clk only.
- Reset values:
  - Active config = DEF_* values; pending slot empty.
  - State IDLE; h_count = v_count = 0; x_pos = y_pos = 0.
  - de, frame_valid, frame_start, line_start, cfg_err = 0; cfg_ready = 1.
  - hsync = ~DEF_HS_POL; vsync = ~DEF_VS_POL.
- States:
  - IDLE: counters held at 0. de, frame_valid and strobes are 0; syncs are at inactive level. en=1 → RUN next cycle, counting starts from (0,0).
  - RUN: counters advance. en=0 → IDLE on the next edge regardless of position; no completion of the line or frame.
- Counters:
  - h_total = active + fp + sync + bp, computed in CNT_W+2 bits; v_total likewise.
  - h_count wraps at h_total-1. v_count increments on the h wrap and wraps at v_total-1.
- Registered outputs, one-cycle latency from counters:
  - de = (h_count < h_active) && (v_count < v_active).
  - frame_valid = v_count < v_active.
  - hsync asserted for h_count in [h_active+h_fp, h_active+h_fp+h_sync); vsync asserted for v_count in the equivalent vertical window.
  - x_pos/y_pos = h_count/v_count when in the active region, otherwise hold their last value.
  - frame_start = (h_count == 0 && v_count == 0 && RUN).
  - line_start = (h_count == 0 && v_count < v_active && RUN).
- Config handshake:
  - Accept on cfg_valid && cfg_ready. Validation is combinational on the offered fields.
  - Reject if any field is 0 or either total > 2^CNT_W. On reject, cfg_err pulses the next cycle and nothing is stored.
  - Valid config is stored in the pending slot; cfg_ready falls the next cycle.
- Pending application:
  - In RUN: applied on the edge where h_count == h_total-1 && v_count == v_total-1. The new frame starts with the new timing, and cfg_ready rises the following cycle.
  - In IDLE: applied on the next edge.
  - Simultaneous accept and frame end: the config just accepted is not applied on that edge; it waits for the next boundary.
- Mid-operation reset: discards pending config, restores DEF_*, returns to IDLE.

Decomposition:
- Shared package vesa_timing_pkg:
  - CNT_W default.
  - timing-config struct (8 fields + 2 polarities).
  - Function computing totals.
  - Default-mode constants matching the 1280x720@60 generator.
- One natural sub-module: vesa_cfg_shadow. It holds the pending slot, validation, cfg_ready/cfg_err and the apply-at-boundary logic. The top level holds the counters, FSM and output decode.

Test Plan:
- Reset release, en=1, defaults: hsync low for exactly 32 clocks starting 1425 clocks after line start; de high 1280 clocks per line; frame period 1600*748 clocks; frame_start once per frame.
- Mid-frame config 8/2/2/2 horizontal, 4/1/1/1 vertical, pol=1 → cfg_ready low until frame end. Next frame has h_total=14, v_total=7, active-high syncs, x_pos 0..7, y_pos 0..3.
- Config with cfg_v_sync=0 → cfg_err high for 1 cycle, cfg_ready stays 1, timing unchanged.
- Second cfg_valid while pending → not accepted (cfg_ready=0); the first config is applied at the boundary, then the second is accepted.
- en deasserted at h_count=500 → next cycle IDLE, counters 0, de 0, syncs inactive. Re-enabling gives frame_start 2 cycles after en rises.
- rst_n low 1 cycle mid-frame with pending config → DEF timing restored, pending discarded, all outputs at reset values on the following edge.

Source files
------------

// File: rtl/vesa_timing_pkg.sv
// rtl/vesa_timing_pkg.sv - shared types, 1280x720@60 defaults and total helper for the VESA timing generator
package vesa_timing_pkg;

  localparam int DEF_CNT_W = 12;
  // Storage width of config fields; the generator's CNT_W must not exceed it.
  localparam int CFG_W = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } gen_state_e;

  typedef struct packed {
    logic [CFG_W-1:0] h_active;
    logic [CFG_W-1:0] h_fp;
    logic [CFG_W-1:0] h_sync;
    logic [CFG_W-1:0] h_bp;
    logic [CFG_W-1:0] v_active;
    logic [CFG_W-1:0] v_fp;
    logic [CFG_W-1:0] v_sync;
    logic [CFG_W-1:0] v_bp;
    logic             hs_pol;
    logic             vs_pol;
  } timing_cfg_t;

  localparam int VESA720_H_ACTIVE = 1280;
  localparam int VESA720_H_FP     = 144;
  localparam int VESA720_H_SYNC   = 32;
  localparam int VESA720_H_BP     = 144;
  localparam int VESA720_V_ACTIVE = 720;
  localparam int VESA720_V_FP     = 3;
  localparam int VESA720_V_SYNC   = 4;
  localparam int VESA720_V_BP     = 21;

  function automatic logic [CFG_W+1:0] calc_total(input logic [CFG_W-1:0] active,
                                                  input logic [CFG_W-1:0] fp,
                                                  input logic [CFG_W-1:0] sync,
                                                  input logic [CFG_W-1:0] bp);
    return {2'b00, active} + {2'b00, fp} + {2'b00, sync} + {2'b00, bp};
  endfunction

endpackage

// File: rtl/vesa_cfg_shadow.sv
// rtl/vesa_cfg_shadow.sv - validates offered timing, holds one pending config, applies it at a boundary
module vesa_cfg_shadow
  import vesa_timing_pkg::*;
#(
  parameter int          CNT_W   = DEF_CNT_W,
  parameter timing_cfg_t DEF_CFG = '0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_valid_i,
  input  timing_cfg_t cfg_i,
  input  logic        boundary_i,
  output logic        cfg_ready_o,
  output logic        cfg_err_o,
  output timing_cfg_t active_o
);

  localparam logic [CNT_W+1:0] MAX_TOTAL = {2'b01, {CNT_W{1'b0}}};

  timing_cfg_t      active_q, active_d, pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d, err_q, err_d;
  logic [CNT_W+1:0] h_tot, v_tot;
  logic             cfg_ok;

  assign h_tot = (CNT_W+2)'(calc_total(cfg_i.h_active, cfg_i.h_fp, cfg_i.h_sync, cfg_i.h_bp));
  assign v_tot = (CNT_W+2)'(calc_total(cfg_i.v_active, cfg_i.v_fp, cfg_i.v_sync, cfg_i.v_bp));

  assign cfg_ok = (cfg_i.h_active != '0) && (cfg_i.h_fp != '0) && (cfg_i.h_sync != '0) &&
                  (cfg_i.h_bp != '0) && (cfg_i.v_active != '0) && (cfg_i.v_fp != '0) &&
                  (cfg_i.v_sync != '0) && (cfg_i.v_bp != '0) &&
                  (h_tot <= MAX_TOTAL) && (v_tot <= MAX_TOTAL);

  // Apply and accept are exclusive: accept needs an empty slot, apply a full one,
  // so a config accepted on a frame-end edge naturally waits for the next boundary.
  always_comb begin
    active_d   = active_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    err_d      = 1'b0;
    if (pend_vld_q && boundary_i) begin
      active_d   = pend_q;
      pend_vld_d = 1'b0;
    end else if (cfg_valid_i && !pend_vld_q) begin
      if (cfg_ok) begin
        pend_d     = cfg_i;
        pend_vld_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active_q   <= DEF_CFG;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      active_q   <= active_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      err_q      <= err_d;
    end
  end

  assign cfg_ready_o = !pend_vld_q;
  assign cfg_err_o   = err_q;
  assign active_o    = active_q;

endmodule

// File: rtl/vesa_timing_gen_prog.sv
// rtl/vesa_timing_gen_prog.sv - runtime-programmable VESA timing generator: counters, run FSM, output decode
module vesa_timing_gen_prog
  import vesa_timing_pkg::*;
#(
  parameter int CNT_W        = DEF_CNT_W,
  parameter int DEF_H_ACTIVE = VESA720_H_ACTIVE,
  parameter int DEF_H_FP     = VESA720_H_FP,
  parameter int DEF_H_SYNC   = VESA720_H_SYNC,
  parameter int DEF_H_BP     = VESA720_H_BP,
  parameter int DEF_V_ACTIVE = VESA720_V_ACTIVE,
  parameter int DEF_V_FP     = VESA720_V_FP,
  parameter int DEF_V_SYNC   = VESA720_V_SYNC,
  parameter int DEF_V_BP     = VESA720_V_BP,
  parameter bit DEF_HS_POL   = 1'b0,
  parameter bit DEF_VS_POL   = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_h_active,
  input  logic [CNT_W-1:0] cfg_h_fp,
  input  logic [CNT_W-1:0] cfg_h_sync,
  input  logic [CNT_W-1:0] cfg_h_bp,
  input  logic [CNT_W-1:0] cfg_v_active,
  input  logic [CNT_W-1:0] cfg_v_fp,
  input  logic [CNT_W-1:0] cfg_v_sync,
  input  logic [CNT_W-1:0] cfg_v_bp,
  input  logic             cfg_hs_pol,
  input  logic             cfg_vs_pol,
  output logic             cfg_err,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             frame_valid,
  output logic             frame_start,
  output logic             line_start,
  output logic [CNT_W-1:0] h_count,
  output logic [CNT_W-1:0] v_count,
  output logic [CNT_W-1:0] x_pos,
  output logic [CNT_W-1:0] y_pos
);

  localparam timing_cfg_t DEF_CFG = '{
    h_active: CFG_W'(DEF_H_ACTIVE), h_fp: CFG_W'(DEF_H_FP),
    h_sync:   CFG_W'(DEF_H_SYNC),   h_bp: CFG_W'(DEF_H_BP),
    v_active: CFG_W'(DEF_V_ACTIVE), v_fp: CFG_W'(DEF_V_FP),
    v_sync:   CFG_W'(DEF_V_SYNC),   v_bp: CFG_W'(DEF_V_BP),
    hs_pol:   DEF_HS_POL,           vs_pol: DEF_VS_POL
  };
  localparam logic [CNT_W+1:0] ONE = 1;

  timing_cfg_t      cfg_offer, act;
  gen_state_e       state_q, state_d;
  logic [CNT_W-1:0] h_q, h_d, v_q, v_d, x_q, x_d, y_q, y_d;
  logic             hs_q, hs_d, vs_q, vs_d, de_q, de_d, fv_q, fv_d, fs_q, fs_d, ls_q, ls_d;
  logic [CNT_W+1:0] hc, vc, h_act, v_act, h_tot, v_tot, hs_beg, hs_end, vs_beg, vs_end;
  logic             h_last, v_last, frame_end, run, in_h, in_v;

  assign cfg_offer = '{
    h_active: CFG_W'(cfg_h_active), h_fp: CFG_W'(cfg_h_fp),
    h_sync:   CFG_W'(cfg_h_sync),   h_bp: CFG_W'(cfg_h_bp),
    v_active: CFG_W'(cfg_v_active), v_fp: CFG_W'(cfg_v_fp),
    v_sync:   CFG_W'(cfg_v_sync),   v_bp: CFG_W'(cfg_v_bp),
    hs_pol:   cfg_hs_pol,           vs_pol: cfg_vs_pol
  };

  vesa_cfg_shadow #(
    .CNT_W  (CNT_W),
    .DEF_CFG(DEF_CFG)
  ) u_shadow (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_valid_i(cfg_valid),
    .cfg_i      (cfg_offer),
    .boundary_i ((state_q == ST_IDLE) || frame_end),
    .cfg_ready_o(cfg_ready),
    .cfg_err_o  (cfg_err),
    .active_o   (act)
  );

  always_comb begin
    hc     = (CNT_W+2)'(h_q);
    vc     = (CNT_W+2)'(v_q);
    h_act  = (CNT_W+2)'(act.h_active);
    v_act  = (CNT_W+2)'(act.v_active);
    h_tot  = (CNT_W+2)'(calc_total(act.h_active, act.h_fp, act.h_sync, act.h_bp));
    v_tot  = (CNT_W+2)'(calc_total(act.v_active, act.v_fp, act.v_sync, act.v_bp));
    hs_beg = h_act + (CNT_W+2)'(act.h_fp);
    hs_end = hs_beg + (CNT_W+2)'(act.h_sync);
    vs_beg = v_act + (CNT_W+2)'(act.v_fp);
    vs_end = vs_beg + (CNT_W+2)'(act.v_sync);
    h_last = (hc == h_tot - ONE);
    v_last = (vc == v_tot - ONE);
    frame_end = (state_q == ST_RUN) && h_last && v_last;

    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    case (state_q)
      ST_IDLE: begin
        h_d = '0;
        v_d = '0;
        if (en) state_d = ST_RUN;
      end
      default: begin
        if (!en) begin
          state_d = ST_IDLE;
          h_d     = '0;
          v_d     = '0;
        end else if (h_last) begin
          h_d = '0;
          v_d = v_last ? '0 : v_q + CNT_W'(1);
        end else begin
          h_d = h_q + CNT_W'(1);
        end
      end
    endcase

    // Gating with en blanks the outputs on the same edge that drops to IDLE.
    run  = (state_q == ST_RUN) && en;
    in_h = hc < h_act;
    in_v = vc < v_act;
    de_d = run && in_h && in_v;
    fv_d = run && in_v;
    fs_d = run && (hc == '0) && (vc == '0);
    ls_d = run && (hc == '0) && in_v;
    hs_d = (run && (hc >= hs_beg) && (hc < hs_end)) ? act.hs_pol : ~act.hs_pol;
    vs_d = (run && (vc >= vs_beg) && (vc < vs_end)) ? act.vs_pol : ~act.vs_pol;
    x_d  = de_d ? h_q : x_q;
    y_d  = de_d ? v_q : y_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      h_q     <= '0;
      v_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      hs_q    <= ~DEF_HS_POL;
      vs_q    <= ~DEF_VS_POL;
      de_q    <= 1'b0;
      fv_q    <= 1'b0;
      fs_q    <= 1'b0;
      ls_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
      x_q     <= x_d;
      y_q     <= y_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      de_q    <= de_d;
      fv_q    <= fv_d;
      fs_q    <= fs_d;
      ls_q    <= ls_d;
    end
  end

  assign h_count     = h_q;
  assign v_count     = v_q;
  assign x_pos       = x_q;
  assign y_pos       = y_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign de          = de_q;
  assign frame_valid = fv_q;
  assign frame_start = fs_q;
  assign line_start  = ls_q;

endmodule

// File: tb/tb_vesa_timing_gen_prog.sv
// tb/tb_vesa_timing_gen_prog.sv - directed self-checking bench for vesa_timing_gen_prog
module tb_vesa_timing_gen_prog;

  localparam int CNT_W = 12;

  logic             clk = 1'b0;
  logic             rst_n, en, cfg_valid, cfg_ready, cfg_hs_pol, cfg_vs_pol, cfg_err;
  logic             hsync, vsync, de, frame_valid, frame_start, line_start;
  logic [CNT_W-1:0] cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp;
  logic [CNT_W-1:0] cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp;
  logic [CNT_W-1:0] h_count, v_count, x_pos, y_pos;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  vesa_timing_gen_prog #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_h_active(cfg_h_active), .cfg_h_fp(cfg_h_fp), .cfg_h_sync(cfg_h_sync), .cfg_h_bp(cfg_h_bp),
    .cfg_v_active(cfg_v_active), .cfg_v_fp(cfg_v_fp), .cfg_v_sync(cfg_v_sync), .cfg_v_bp(cfg_v_bp),
    .cfg_hs_pol(cfg_hs_pol), .cfg_vs_pol(cfg_vs_pol), .cfg_err(cfg_err),
    .hsync(hsync), .vsync(vsync), .de(de), .frame_valid(frame_valid),
    .frame_start(frame_start), .line_start(line_start),
    .h_count(h_count), .v_count(v_count), .x_pos(x_pos), .y_pos(y_pos)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_cfg(input int ha, hf, hs, hb, va, vf, vs, vb, input bit hp, vp);
    cfg_h_active = CNT_W'(ha); cfg_h_fp = CNT_W'(hf); cfg_h_sync = CNT_W'(hs); cfg_h_bp = CNT_W'(hb);
    cfg_v_active = CNT_W'(va); cfg_v_fp = CNT_W'(vf); cfg_v_sync = CNT_W'(vs); cfg_v_bp = CNT_W'(vb);
    cfg_hs_pol = hp; cfg_vs_pol = vp;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; cfg_valid = 1'b0;
    set_cfg(1280, 144, 32, 144, 720, 3, 4, 21, 1'b0, 1'b0);
    repeat (3) tick();
    tests_run++;
    if ({hsync, vsync, de, frame_valid, frame_start, line_start, cfg_err, cfg_ready} !== 8'b1100_0001) begin
      tests_failed++;
      $display("FAIL reset_flags got=%b exp=11000001",
               {hsync, vsync, de, frame_valid, frame_start, line_start, cfg_err, cfg_ready});
    end
    tests_run++;
    if ({h_count, v_count, x_pos, y_pos} !== '0) begin
      tests_failed++;
      $display("FAIL reset_counts got h=%0d v=%0d x=%0d y=%0d exp all 0", h_count, v_count, x_pos, y_pos);
    end
    rst_n = 1'b1;
    tick();
    tests_run++;
    if (h_count !== '0 || hsync !== 1'b1 || de !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_hold got h=%0d hsync=%b de=%b exp 0/1/0", h_count, hsync, de);
    end
  endtask

  task automatic test_defaults();
    int period, de_cnt, hs_lo, hs_first_h, fs_cnt, vs_lo;
    en = 1'b1;
    tick();
    tests_run++;
    if (frame_start !== 1'b0 || h_count !== '0) begin
      tests_failed++;
      $display("FAIL run_entry got fs=%b h=%0d exp 0/0", frame_start, h_count);
    end
    tick();
    tests_run++;
    if ({frame_start, line_start, de} !== 3'b111 || x_pos !== '0) begin
      tests_failed++;
      $display("FAIL first_pixel got fs/ls/de=%b x=%0d exp 111 x=0", {frame_start, line_start, de}, x_pos);
    end
    period = 0; de_cnt = 1; hs_lo = 0; hs_first_h = -1; fs_cnt = 0; vs_lo = 0;
    for (int i = 1; i <= 1700; i++) begin
      tick();
      if (line_start) begin period = i; break; end
      if (de) de_cnt++;
      if (!hsync) begin
        if (hs_first_h < 0) hs_first_h = int'(h_count);
        hs_lo++;
      end
      if (frame_start) fs_cnt++;
      if (!vsync) vs_lo++;
    end
    tests_run++;
    if (period != 1600) begin
      tests_failed++; $display("FAIL def_line_period got=%0d exp=1600", period);
    end
    tests_run++;
    if (de_cnt != 1280) begin
      tests_failed++; $display("FAIL def_de_width got=%0d exp=1280", de_cnt);
    end
    tests_run++;
    if (hs_lo != 32 || hs_first_h != 1425) begin
      tests_failed++; $display("FAIL def_hsync got width=%0d at_h=%0d exp 32 at 1425", hs_lo, hs_first_h);
    end
    tests_run++;
    if (fs_cnt != 0 || vs_lo != 0) begin
      tests_failed++; $display("FAIL def_no_fs_vs got fs=%0d vs_lo=%0d exp 0/0", fs_cnt, vs_lo);
    end
  endtask

  task automatic test_bad_cfg();
    int period;
    bit seen;
    set_cfg(8, 2, 2, 2, 4, 1, 0, 1, 1'b1, 1'b1);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    tests_run++;
    if (cfg_err !== 1'b1 || cfg_ready !== 1'b1) begin
      tests_failed++; $display("FAIL zero_field_err got err=%b rdy=%b exp 1/1", cfg_err, cfg_ready);
    end
    tick();
    tests_run++;
    if (cfg_err !== 1'b0 || cfg_ready !== 1'b1) begin
      tests_failed++; $display("FAIL err_one_cycle got err=%b rdy=%b exp 0/1", cfg_err, cfg_ready);
    end
    set_cfg(4000, 32, 32, 33, 720, 3, 4, 21, 1'b0, 1'b0);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    tests_run++;
    if (cfg_err !== 1'b1 || cfg_ready !== 1'b1) begin
      tests_failed++; $display("FAIL total_4097_err got err=%b rdy=%b exp 1/1", cfg_err, cfg_ready);
    end
    seen = 1'b0;
    for (int i = 0; i < 1700; i++) begin
      tick();
      if (line_start) begin seen = 1'b1; break; end
    end
    period = 0;
    for (int i = 1; i <= 1700 && seen; i++) begin
      tick();
      if (line_start) begin period = i; break; end
    end
    tests_run++;
    if (period != 1600) begin
      tests_failed++; $display("FAIL timing_unchanged got period=%0d exp=1600", period);
    end
  endtask

  task automatic test_disable();
    bit seen = 1'b0;
    for (int i = 0; i < 1700; i++) begin
      if (h_count == 12'd500) begin seen = 1'b1; break; end
      tick();
    end
    en = 1'b0;
    tick();
    tests_run++;
    if (!seen || h_count !== '0 || v_count !== '0 || {de, frame_valid, line_start, hsync, vsync} !== 5'b00011) begin
      tests_failed++;
      $display("FAIL disable got seen=%b h=%0d v=%0d de/fv/ls/hs/vs=%b exp 1 0 0 00011",
               seen, h_count, v_count, {de, frame_valid, line_start, hsync, vsync});
    end
  endtask

  task automatic test_idle_cfg();
    set_cfg(8, 2, 2, 2, 4, 1, 1, 1, 1'b1, 1'b1);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    tests_run++;
    if (cfg_ready !== 1'b0 || cfg_err !== 1'b0) begin
      tests_failed++; $display("FAIL idle_accept got rdy=%b err=%b exp 0/0", cfg_ready, cfg_err);
    end
    tick();
    tests_run++;
    if (cfg_ready !== 1'b1) begin
      tests_failed++; $display("FAIL idle_apply got rdy=%b exp 1", cfg_ready);
    end
    tick();
    tests_run++;
    if (hsync !== 1'b0 || vsync !== 1'b0) begin
      tests_failed++; $display("FAIL new_pol_idle got hs=%b vs=%b exp 0/0", hsync, vsync);
    end
  endtask

  task automatic test_small_frame();
    int period, de_cnt, ls_cnt, hs_hi, vs_hi, fv_cnt, max_x, max_y;
    en = 1'b1;
    tick();
    tests_run++;
    if (frame_start !== 1'b0) begin
      tests_failed++; $display("FAIL reenable_early got fs=%b exp 0", frame_start);
    end
    tick();
    tests_run++;
    if (frame_start !== 1'b1) begin
      tests_failed++; $display("FAIL reenable_fs got fs=%b exp 1", frame_start);
    end
    period = 0; de_cnt = int'(de); ls_cnt = int'(line_start); hs_hi = int'(hsync);
    vs_hi = int'(vsync); fv_cnt = int'(frame_valid); max_x = int'(x_pos); max_y = int'(y_pos);
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (frame_start) begin period = i; break; end
      de_cnt += int'(de); ls_cnt += int'(line_start); hs_hi += int'(hsync);
      vs_hi += int'(vsync); fv_cnt += int'(frame_valid);
      if (de && int'(x_pos) > max_x) max_x = int'(x_pos);
      if (de && int'(y_pos) > max_y) max_y = int'(y_pos);
    end
    tests_run++;
    if (period != 98) begin
      tests_failed++; $display("FAIL small_period got=%0d exp=98", period);
    end
    tests_run++;
    if (de_cnt != 32 || ls_cnt != 4 || fv_cnt != 56) begin
      tests_failed++; $display("FAIL small_active got de=%0d ls=%0d fv=%0d exp 32/4/56", de_cnt, ls_cnt, fv_cnt);
    end
    tests_run++;
    if (hs_hi != 14 || vs_hi != 14) begin
      tests_failed++; $display("FAIL small_sync got hs_hi=%0d vs_hi=%0d exp 14/14", hs_hi, vs_hi);
    end
    tests_run++;
    if (max_x != 7 || max_y != 3) begin
      tests_failed++; $display("FAIL small_xy got max_x=%0d max_y=%0d exp 7/3", max_x, max_y);
    end
  endtask

  task automatic test_back_to_back();
    int rdy_cnt, period, hs_lo, de_cnt, hs_hi;
    bit seen = 1'b0;
    repeat (20) tick();
    set_cfg(4, 1, 1, 1, 2, 1, 1, 1, 1'b0, 1'b0);
    cfg_valid = 1'b1;
    tick();
    tests_run++;
    if (cfg_ready !== 1'b0) begin
      tests_failed++; $display("FAIL midframe_accept got rdy=%b exp 0", cfg_ready);
    end
    set_cfg(6, 1, 1, 1, 3, 1, 1, 1, 1'b1, 1'b1);
    rdy_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (frame_start) begin seen = 1'b1; break; end
      if (cfg_ready) rdy_cnt++;
    end
    cfg_valid = 1'b0;
    tests_run++;
    if (!seen || rdy_cnt != 1 || cfg_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL pending_block got seen=%b ready_cycles=%0d rdy_now=%b exp 1/1/0", seen, rdy_cnt, cfg_ready);
    end
    period = 0; hs_lo = int'(!hsync);
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (frame_start) begin period = i; break; end
      if (!hsync) hs_lo++;
    end
    tests_run++;
    if (period != 35 || hs_lo != 5 || cfg_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL first_cfg_frame got period=%0d hs_lo=%0d rdy=%b exp 35/5/1", period, hs_lo, cfg_ready);
    end
    period = 0; de_cnt = int'(de); hs_hi = int'(hsync);
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (frame_start) begin period = i; break; end
      de_cnt += int'(de); hs_hi += int'(hsync);
    end
    tests_run++;
    if (period != 54 || de_cnt != 18 || hs_hi != 6) begin
      tests_failed++;
      $display("FAIL second_cfg_frame got period=%0d de=%0d hs_hi=%0d exp 54/18/6", period, de_cnt, hs_hi);
    end
  endtask

  task automatic test_reset_midframe();
    int period, hs_lo;
    repeat (10) tick();
    set_cfg(8, 2, 2, 2, 4, 1, 1, 1, 1'b1, 1'b1);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    tests_run++;
    if (cfg_ready !== 1'b0) begin
      tests_failed++; $display("FAIL pre_reset_pending got rdy=%b exp 0", cfg_ready);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tests_run++;
    if ({hsync, vsync, de, frame_valid, frame_start, line_start, cfg_err, cfg_ready} !== 8'b1100_0001 ||
        {h_count, v_count, x_pos, y_pos} !== '0) begin
      tests_failed++;
      $display("FAIL midframe_reset got flags=%b h=%0d v=%0d x=%0d y=%0d exp 11000001 and zeros",
               {hsync, vsync, de, frame_valid, frame_start, line_start, cfg_err, cfg_ready},
               h_count, v_count, x_pos, y_pos);
    end
    tick();
    tick();
    tests_run++;
    if (frame_start !== 1'b1) begin
      tests_failed++; $display("FAIL post_reset_fs got fs=%b exp 1", frame_start);
    end
    period = 0; hs_lo = 0;
    for (int i = 1; i <= 1700; i++) begin
      tick();
      if (line_start) begin period = i; break; end
      if (!hsync) hs_lo++;
    end
    tests_run++;
    if (period != 1600 || hs_lo != 32) begin
      tests_failed++; $display("FAIL defaults_restored got period=%0d hs_lo=%0d exp 1600/32", period, hs_lo);
    end
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_bad_cfg();
    test_disable();
    test_idle_cfg();
    test_small_frame();
    test_back_to_back();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
